// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALU control codes, alu_op classes,
// R-type funct codes and the operand/control slot layout.
package ex_stage_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_XNOR = 4'b1100
  } alu_ctl_e;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_RTYPE = 2'b10,
    OP_RSVD  = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_XNOR = 6'b100111;

  typedef struct packed {
    alu_ctl_e          ctl;
    logic              illegal;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [4:0]        rd;
  } s1_t;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU: add/sub with signed overflow, and/or/xnor, signed set-less-than.
module ex_stage_alu
  import ex_stage_pkg::*;
(
  input  alu_ctl_e          ctl_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [XLEN-1:0]   res_o,
  output logic              zero_o,
  output logic              ovf_o
);

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

  always_comb begin
    res_o = '0;
    ovf_o = 1'b0;
    case (ctl_i)
      ALU_AND:  res_o = a_i & b_i;
      ALU_OR:   res_o = a_i | b_i;
      ALU_ADD: begin
        res_o = sum;
        ovf_o = (a_i[XLEN-1] == b_i[XLEN-1]) && (sum[XLEN-1] != a_i[XLEN-1]);
      end
      ALU_SUB: begin
        res_o = diff;
        ovf_o = (a_i[XLEN-1] != b_i[XLEN-1]) && (diff[XLEN-1] != a_i[XLEN-1]);
      end
      ALU_SLT:  res_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_XNOR: res_o = ~(a_i ^ b_i);
      default:  res_o = '0;
    endcase
  end

  assign zero_o = (res_o == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: decode to ALU control, operand slot S1 feeding the ALU,
// result slot S2 driving the valid/ready output, saturating overflow counter.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [15:0]      imm,
  input  logic             alu_src,
  input  logic [4:0]       rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic [4:0]       out_rd,
  output logic [7:0]       ovf_count
);

  alu_ctl_e         dec_ctl;
  logic             dec_illegal;
  logic [WIDTH-1:0] opb;

  s1_t              s1_q, s1_d;
  logic             s1_valid_q, s1_valid_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;
  logic [4:0]       rd_q, rd_d;
  logic [7:0]       ovf_cnt_q, ovf_cnt_d;

  logic             s2_load, in_xfer, out_xfer;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero, alu_ovf;

  always_comb begin
    dec_ctl     = ALU_ADD;
    dec_illegal = 1'b0;
    case (alu_op_e'(alu_op))
      OP_ADD:   dec_ctl = ALU_ADD;
      OP_SUB:   dec_ctl = ALU_SUB;
      OP_RTYPE: begin
        case (funct)
          FUNCT_ADD:  dec_ctl = ALU_ADD;
          FUNCT_SUB:  dec_ctl = ALU_SUB;
          FUNCT_AND:  dec_ctl = ALU_AND;
          FUNCT_OR:   dec_ctl = ALU_OR;
          FUNCT_SLT:  dec_ctl = ALU_SLT;
          FUNCT_XNOR: dec_ctl = ALU_XNOR;
          default:    dec_illegal = 1'b1;
        endcase
      end
      default:  dec_illegal = 1'b1;
    endcase
  end

  assign opb = alu_src ? {{(WIDTH-16){imm[15]}}, imm} : rt_val;

  // S2 can take S1 whenever its current result is absent or leaving this cycle.
  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  ex_stage_alu u_alu (
    .ctl_i  (s1_q.ctl),
    .a_i    (s1_q.a),
    .b_i    (s1_q.b),
    .res_o  (alu_res),
    .zero_o (alu_zero),
    .ovf_o  (alu_ovf)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    ill_d       = ill_q;
    rd_d        = rd_q;
    ovf_cnt_d   = ovf_cnt_q;

    if (in_xfer) begin
      s1_valid_d   = 1'b1;
      s1_d.ctl     = dec_ctl;
      s1_d.illegal = dec_illegal;
      s1_d.a       = rs_val;
      s1_d.b       = opb;
      s1_d.rd      = rd;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      out_valid_d = 1'b1;
      res_d       = s1_q.illegal ? '0 : alu_res;
      zero_d      = !s1_q.illegal && alu_zero;
      ovf_d       = !s1_q.illegal && alu_ovf;
      ill_d       = s1_q.illegal;
      rd_d        = s1_q.rd;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (out_xfer && ovf_q && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
      rd_q        <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      ill_q       <= ill_d;
      rd_q        <= rd_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_res     = res_q;
  assign out_zero    = zero_q;
  assign out_ovf     = ovf_q;
  assign out_illegal = ill_q;
  assign out_rd      = rd_q;
  assign ovf_count   = ovf_cnt_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: latency, ALU results, flags, backpressure,
// illegal ops, overflow counter saturation and asynchronous reset.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [15:0] imm;
  logic        alu_src;
  logic [4:0]  rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic        out_zero;
  logic        out_ovf;
  logic        out_illegal;
  logic [4:0]  out_rd;
  logic [7:0]  ovf_count;

  int checks = 0;
  int errors = 0;

  ex_stage #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_op      (alu_op),
    .funct       (funct),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .imm         (imm),
    .alu_src     (alu_src),
    .rd          (rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_res     (out_res),
    .out_zero    (out_zero),
    .out_ovf     (out_ovf),
    .out_illegal (out_illegal),
    .out_rd      (out_rd),
    .ovf_count   (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] i, input logic src, input logic [4:0] r);
    in_valid = v;
    alu_op   = op;
    funct    = f;
    rs_val   = a;
    rt_val   = b;
    imm      = i;
    alu_src  = src;
    rd       = r;
  endtask

  task automatic idle;
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0, 16'd0, 1'b0, 5'd0);
  endtask

  task automatic test_reset;
    idle();
    out_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0h want 1", in_ready); end
    checks++; if (out_res !== 32'd0 || out_rd !== 5'd0) begin errors++; $display("FAIL reset_res_rd got %0h/%0h want 0/0", out_res, out_rd); end
    checks++; if ({out_zero, out_ovf, out_illegal} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {out_zero, out_ovf, out_illegal}); end
    checks++; if (ovf_count !== 8'd0) begin errors++; $display("FAIL reset_ovf_count got %0d want 0", ovf_count); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_add_latency;
    drive(1'b1, 2'b10, 6'b100000, 32'd256, 32'd256, 16'd0, 1'b0, 5'd7);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready got %0h want 1", in_ready); end
    tick();
    idle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_latency1 out_valid got %0h want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency2 out_valid got %0h want 1", out_valid); end
    checks++; if (out_res !== 32'd512) begin errors++; $display("FAIL add_res got %0d want 512", out_res); end
    checks++; if (out_zero !== 1'b0 || out_ovf !== 1'b0 || out_illegal !== 1'b0) begin errors++; $display("FAIL add_flags got z%0h o%0h i%0h want 000", out_zero, out_ovf, out_illegal); end
    checks++; if (out_rd !== 5'd7) begin errors++; $display("FAIL add_rd got %0d want 7", out_rd); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain out_valid got %0h want 0", out_valid); end
  endtask

  task automatic test_overflow;
    drive(1'b1, 2'b10, 6'b100000, 32'h7FFF_FFFF, 32'd1, 16'd0, 1'b0, 5'd1);
    tick(); idle(); tick();
    checks++; if (out_res !== 32'h8000_0000) begin errors++; $display("FAIL ovf_add_res got %0h want 80000000", out_res); end
    checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL ovf_add_flag got %0h want 1", out_ovf); end
    tick();
    checks++; if (ovf_count !== 8'd1) begin errors++; $display("FAIL ovf_count1 got %0d want 1", ovf_count); end
    drive(1'b1, 2'b10, 6'b100010, 32'h8000_0000, 32'd1, 16'd0, 1'b0, 5'd2);
    tick(); idle(); tick();
    checks++; if (out_res !== 32'h7FFF_FFFF) begin errors++; $display("FAIL ovf_sub_res got %0h want 7fffffff", out_res); end
    checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sub_flag got %0h want 1", out_ovf); end
    tick();
    checks++; if (ovf_count !== 8'd2) begin errors++; $display("FAIL ovf_count2 got %0d want 2", ovf_count); end
  endtask

  task automatic test_beq_lw;
    drive(1'b1, 2'b01, 6'd0, -32'sd50, -32'sd50, 16'd0, 1'b0, 5'd3);
    tick(); idle(); tick();
    checks++; if (out_res !== 32'd0 || out_zero !== 1'b1) begin errors++; $display("FAIL beq_zero got res %0h z %0h want 0/1", out_res, out_zero); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL beq_ovf got %0h want 0", out_ovf); end
    tick();
    drive(1'b1, 2'b00, 6'd0, 32'd100, 32'd12345, 16'hFFF6, 1'b1, 5'd4);
    tick(); idle(); tick();
    checks++; if (out_res !== 32'd90 || out_zero !== 1'b0) begin errors++; $display("FAIL lw_imm got res %0d z %0h want 90/0", out_res, out_zero); end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [1:0]  op_v [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [5:0]  fn_v [8] = '{6'b101010, 6'b101010, 6'b101010, 6'b101010,
                               6'b100100, 6'b100101, 6'b100111, 6'b100111};
    logic [31:0] a_v  [8] = '{-32'sd10, 32'd10, 32'd12, -32'sd12,
                               32'h7FFF_FFFF, 32'h0000_00F0, 32'h0000_0000, 32'h0F0F_0F0F};
    logic [31:0] b_v  [8] = '{32'd20, 32'd12, 32'd10, -32'sd14,
                               32'h0000_0001, 32'h0000_000F, 32'hFFFF_FFFF, 32'h0F0F_0F0F};
    logic [31:0] e_v  [8] = '{32'd1, 32'd1, 32'd0, 32'd0,
                               32'h0000_0001, 32'h0000_00FF, 32'h0000_0000, 32'hFFFF_FFFF};
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c >= 2) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %0h want 1", c-2, out_valid); end
        checks++; if (out_res !== e_v[c-2]) begin errors++; $display("FAIL b2b_res[%0d] got %0h want %0h", c-2, out_res, e_v[c-2]); end
        checks++; if (out_zero !== (e_v[c-2] == 32'd0) || out_ovf !== 1'b0) begin errors++; $display("FAIL b2b_flags[%0d] got z%0h o%0h want z%0h o0", c-2, out_zero, out_ovf, (e_v[c-2] == 32'd0)); end
        checks++; if (out_rd !== 5'(c-2)) begin errors++; $display("FAIL b2b_rd[%0d] got %0d want %0d", c-2, out_rd, c-2); end
      end
      if (c < 8) begin
        drive(1'b1, op_v[c], fn_v[c], a_v[c], b_v[c], 16'd0, 1'b0, 5'(c));
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %0h want 1", c, in_ready); end
      end else begin
        idle();
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0h want 0", out_valid); end
  endtask

  task automatic test_illegal;
    logic [1:0]  op_v [4] = '{2'b10, 2'b10, 2'b11, 2'b00};
    logic [5:0]  fn_v [4] = '{6'b100000, 6'b000000, 6'b100000, 6'b000000};
    logic [31:0] a_v  [4] = '{32'd3, 32'd5, 32'h7FFF_FFFF, 32'd1};
    logic [31:0] b_v  [4] = '{32'd4, 32'd5, 32'd1, 32'd1};
    logic [31:0] e_v  [4] = '{32'd7, 32'd0, 32'd0, 32'd2};
    logic        i_v  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c >= 2) begin
        checks++; if (out_valid !== 1'b1 || out_rd !== 5'(20 + c - 2)) begin errors++; $display("FAIL ill_order[%0d] got v%0h rd%0d want v1 rd%0d", c-2, out_valid, out_rd, 20 + c - 2); end
        checks++; if (out_res !== e_v[c-2] || out_illegal !== i_v[c-2]) begin errors++; $display("FAIL ill_res[%0d] got %0h/i%0h want %0h/i%0h", c-2, out_res, out_illegal, e_v[c-2], i_v[c-2]); end
        checks++; if (out_ovf !== 1'b0 || out_zero !== 1'b0) begin errors++; $display("FAIL ill_flags[%0d] got z%0h o%0h want 0/0", c-2, out_zero, out_ovf); end
      end
      if (c < 4) drive(1'b1, op_v[c], fn_v[c], a_v[c], b_v[c], 16'd0, 1'b0, 5'(20 + c));
      else idle();
      tick();
    end
  endtask

  task automatic test_backpressure;
    logic [1:0]  op_v [4] = '{2'b00, 2'b00, 2'b01, 2'b00};
    logic [31:0] a_v  [4] = '{32'd1, 32'd10, 32'd5, 32'd7};
    logic [31:0] b_v  [4] = '{32'd2, 32'd20, 32'd3, 32'd999};
    logic [15:0] i_v  [4] = '{16'd0, 16'd0, 16'd0, 16'd1};
    logic        s_v  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] e_v  [4] = '{32'd3, 32'd30, 32'd2, 32'd8};
    int sent = 0;
    int rcv  = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = (cyc >= 5);
      if (sent < 4) drive(1'b1, op_v[sent], 6'd0, a_v[sent], b_v[sent], i_v[sent], s_v[sent], 5'(10 + sent));
      else idle();
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %0h want 0", cyc, in_ready); end
        checks++; if (out_valid !== 1'b1 || out_res !== 32'd3 || out_rd !== 5'd10) begin errors++; $display("FAIL bp_hold[%0d] got v%0h %0h rd%0d want v1 3 rd10", cyc, out_valid, out_res, out_rd); end
      end
      if (cyc == 4) begin
        checks++; if (sent !== 2) begin errors++; $display("FAIL bp_accepted got %0d want 2", sent); end
      end
      if (out_valid && out_ready) begin
        checks++; if (out_res !== e_v[rcv] || out_rd !== 5'(10 + rcv)) begin errors++; $display("FAIL bp_out[%0d] got %0h rd%0d want %0h rd%0d", rcv, out_res, out_rd, e_v[rcv], 10 + rcv); end
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
      if (rcv == 4) break;
    end
    idle();
    checks++; if (rcv !== 4 || sent !== 4) begin errors++; $display("FAIL bp_complete got rcv %0d sent %0d want 4/4", rcv, sent); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %0h want 0", out_valid); end
  endtask

  task automatic test_saturation;
    out_ready = 1'b1;
    drive(1'b1, 2'b10, 6'b100000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 16'd0, 1'b0, 5'd9);
    for (int c = 0; c < 260; c++) tick();
    idle();
    tick(); tick(); tick();
    checks++; if (ovf_count !== 8'd255) begin errors++; $display("FAIL ovf_saturate got %0d want 255", ovf_count); end
  endtask

  task automatic test_reset_midflight;
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 6'b100000, 32'h7FFF_FFFF, 32'd1, 16'd0, 1'b0, 5'd5);
    tick();
    drive(1'b1, 2'b00, 6'd0, 32'd8, 32'd8, 16'd0, 1'b0, 5'd6);
    tick();
    idle();
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_full got v%0h r%0h want 1/0", out_valid, in_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_res !== 32'd0 || out_rd !== 5'd0) begin errors++; $display("FAIL mid_async_clear got v%0h %0h rd%0d want 0", out_valid, out_res, out_rd); end
    checks++; if (ovf_count !== 8'd0) begin errors++; $display("FAIL mid_ovf_count got %0d want 0", ovf_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %0h want 1", in_ready); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 2'b00, 6'd0, 32'd40, 32'd2, 16'd0, 1'b0, 5'd17);
    tick();
    idle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale got %0h want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_res !== 32'd42 || out_rd !== 5'd17) begin errors++; $display("FAIL mid_first_accept got v%0h %0d rd%0d want v1 42 rd17", out_valid, out_res, out_rd); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_drain got %0h want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_overflow();
    test_beq_lw();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_saturation();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without completing the sequence");
    $fatal(1);
  end

endmodule
